// File: rtl/lv_wdg_pkg.sv
// Shared types and default sizing for the LV watchdog / HV-link scan engine.
package lv_wdg_pkg;

  typedef enum logic [1:0] {
    SCAN_IDLE,
    SCAN_GAP,
    SCAN_REQ,
    SCAN_WAIT
  } scan_state_t;

  localparam int DEF_PRESCALE  = 64;
  localparam int DEF_SCAN_PRD  = 1000;
  localparam int DEF_ACK_TMO   = 200;
  localparam int DEF_RETRY_MAX = 3;

  // Width of the debug retry readback port
  localparam int RETRY_W = 2;

  // Bits needed for a counter running 0..n-1, never less than one bit
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_PRE_W = cnt_w(DEF_PRESCALE);
  localparam int DEF_GAP_W = cnt_w(DEF_SCAN_PRD);
  localparam int DEF_ACK_W = cnt_w(DEF_ACK_TMO);

endpackage

// File: rtl/lv_owt_scan_ctrl.sv
// Periodic OWT scan sequencer: gap timer, request/ack handshake, ack timeout
// and consecutive-failure retry counter. Flags a link failure for one cycle.
module lv_owt_scan_ctrl
  import lv_wdg_pkg::*;
#(
  parameter int SCAN_PRD  = DEF_SCAN_PRD,
  parameter int ACK_TMO   = DEF_ACK_TMO,
  parameter int RETRY_MAX = DEF_RETRY_MAX
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               en,
  input  logic               ack,
  input  logic               crc_ok,
  output logic               scan_req,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic               link_fail
);

  localparam int GAP_W = cnt_w(SCAN_PRD);
  localparam int ACK_W = cnt_w(ACK_TMO);
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(SCAN_PRD - 1);
  localparam logic [GAP_W-1:0]   GAP_FIRST  = GAP_W'(1);
  localparam logic [ACK_W-1:0]   ACK_LAST   = ACK_W'(ACK_TMO - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(RETRY_MAX - 1);

  scan_state_t        state, state_nx;
  logic [GAP_W-1:0]   gap_cnt, gap_nx;
  logic [ACK_W-1:0]   ack_tmr, ack_nx;
  logic [RETRY_W-1:0] retry_q, retry_nx;
  logic               req_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= SCAN_IDLE;
      gap_cnt <= '0;
      ack_tmr <= '0;
      retry_q <= '0;
      req_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      gap_cnt <= gap_nx;
      ack_tmr <= ack_nx;
      retry_q <= retry_nx;
      req_q   <= (state_nx == SCAN_WAIT);
    end
  end

  always_comb begin
    state_nx  = state;
    gap_nx    = gap_cnt;
    ack_nx    = ack_tmr;
    retry_nx  = retry_q;
    link_fail = 1'b0;
    if (!en) begin
      state_nx = SCAN_IDLE;
      gap_nx   = '0;
      ack_nx   = '0;
      retry_nx = '0;
    end else begin
      unique case (state)
        // The enable cycle itself counts as the first gap cycle
        SCAN_IDLE: begin
          state_nx = SCAN_GAP;
          gap_nx   = GAP_FIRST;
        end
        SCAN_GAP: begin
          if (gap_cnt >= GAP_LAST) begin
            state_nx = SCAN_REQ;
            gap_nx   = '0;
          end else begin
            gap_nx = gap_cnt + GAP_W'(1);
          end
        end
        SCAN_REQ: begin
          state_nx = SCAN_WAIT;
          ack_nx   = '0;
        end
        // A good ack takes priority over an ack timeout in the same cycle
        SCAN_WAIT: begin
          if (ack && crc_ok) begin
            retry_nx = '0;
            state_nx = SCAN_GAP;
            gap_nx   = '0;
          end else if (ack || (ack_tmr == ACK_LAST)) begin
            if (retry_q == RETRY_LAST) begin
              link_fail = 1'b1;
              retry_nx  = '0;
              state_nx  = SCAN_GAP;
              gap_nx    = '0;
            end else begin
              retry_nx = retry_q + RETRY_W'(1);
              state_nx = SCAN_REQ;
            end
          end else begin
            ack_nx = ack_tmr + ACK_W'(1);
          end
        end
        default: state_nx = SCAN_IDLE;
      endcase
    end
  end

  assign scan_req  = req_q;
  assign retry_cnt = retry_q;

endmodule

// File: rtl/lv_wdg_scan.sv
// LV watchdog and HV-link scan engine: watchdog counters, sticky error flags.
// Define LV_WDG_WINDOW_EN to reject refreshes arriving in the early window.
module lv_wdg_scan
  import lv_wdg_pkg::*;
#(
  parameter int PRESCALE  = DEF_PRESCALE,
  parameter int WDG_CFG_W = 8,
  parameter int SCAN_PRD  = DEF_SCAN_PRD,
  parameter int ACK_TMO   = DEF_ACK_TMO,
  parameter int RETRY_MAX = DEF_RETRY_MAX
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_wdg_scan_en,
  input  logic [WDG_CFG_W-1:0] i_reg_wdg_tmo_cfg,
  input  logic                 i_spi_wdg_rfsh,
  input  logic                 i_reg_wdg_err_clr,
  input  logic                 i_reg_owt_err_clr,
  output logic                 o_scan_req,
  input  logic                 i_scan_ack,
  input  logic                 i_scan_crc_ok,
  output logic                 o_wdg_tmo_err,
  output logic                 o_owt_com_err,
  output logic [RETRY_W-1:0]   o_retry_cnt
);

  localparam int PRE_W = cnt_w(PRESCALE);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0]     pre_cnt, pre_nx;
  logic [WDG_CFG_W-1:0] tick_cnt, tick_nx;
  logic                 wdg_run, wdg_set, link_fail;
  logic                 wdg_err_q, owt_err_q;

  assign wdg_run = i_wdg_scan_en && (i_reg_wdg_tmo_cfg != '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pre_cnt  <= '0;
      tick_cnt <= '0;
    end else begin
      pre_cnt  <= pre_nx;
      tick_cnt <= tick_nx;
    end
  end

  // Refresh is checked before the terminal count so it always wins the tie
  always_comb begin
    pre_nx  = pre_cnt;
    tick_nx = tick_cnt;
    wdg_set = 1'b0;
    if (!wdg_run) begin
      pre_nx  = '0;
      tick_nx = '0;
    end else if (i_spi_wdg_rfsh) begin
      pre_nx  = '0;
      tick_nx = '0;
`ifdef LV_WDG_WINDOW_EN
      wdg_set = (tick_cnt < (i_reg_wdg_tmo_cfg >> 1));
`endif
    end else if (tick_cnt == i_reg_wdg_tmo_cfg) begin
      wdg_set = 1'b1;
      pre_nx  = '0;
      tick_nx = '0;
    end else if (pre_cnt == PRE_LAST) begin
      pre_nx  = '0;
      tick_nx = tick_cnt + WDG_CFG_W'(1);
    end else begin
      pre_nx = pre_cnt + PRE_W'(1);
    end
  end

  // Sticky flags survive enable drop; a set beats a clear in the same cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wdg_err_q <= 1'b0;
      owt_err_q <= 1'b0;
    end else begin
      if (wdg_set) wdg_err_q <= 1'b1;
      else if (i_reg_wdg_err_clr) wdg_err_q <= 1'b0;
      if (link_fail) owt_err_q <= 1'b1;
      else if (i_reg_owt_err_clr) owt_err_q <= 1'b0;
    end
  end

  lv_owt_scan_ctrl #(
    .SCAN_PRD  (SCAN_PRD),
    .ACK_TMO   (ACK_TMO),
    .RETRY_MAX (RETRY_MAX)
  ) u_scan (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .en        (i_wdg_scan_en),
    .ack       (i_scan_ack),
    .crc_ok    (i_scan_crc_ok),
    .scan_req  (o_scan_req),
    .retry_cnt (o_retry_cnt),
    .link_fail (link_fail)
  );

  assign o_wdg_tmo_err = wdg_err_q;
  assign o_owt_com_err = owt_err_q;

endmodule

// File: tb/tb_lv_wdg_scan.sv
// Directed and randomized bench for lv_wdg_scan; honours LV_WDG_WINDOW_EN.
module tb_lv_wdg_scan;

  localparam int P    = 8;
  localparam int PRD  = 10;
  localparam int TMO  = 20;
  localparam int RMAX = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, rfsh = 1'b0, wclr = 1'b0, oclr = 1'b0, ack = 1'b0, crc = 1'b0;
  logic [7:0] cfg = 8'd0;
  logic       req, wdg_err, owt_err;
  logic [1:0] retry;

  int checks = 0;
  int failures = 0;
  int t = 0;
  int mc = 0;
  logic merr = 1'b0;
  int rises[$];
  int lens[$];
  int retry_hist [0:255];
  int owt_hist [0:255];
  bit found;

  always #5 clk = ~clk;

  lv_wdg_scan #(
    .PRESCALE  (P),
    .WDG_CFG_W (8),
    .SCAN_PRD  (PRD),
    .ACK_TMO   (TMO),
    .RETRY_MAX (RMAX)
  ) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_wdg_scan_en     (en),
    .i_reg_wdg_tmo_cfg (cfg),
    .i_spi_wdg_rfsh    (rfsh),
    .i_reg_wdg_err_clr (wclr),
    .i_reg_owt_err_clr (oclr),
    .o_scan_req        (req),
    .i_scan_ack        (ack),
    .i_scan_crc_ok     (crc),
    .o_wdg_tmo_err     (wdg_err),
    .o_owt_com_err     (owt_err),
    .o_retry_cnt       (retry)
  );

  // Carries the currently driven inputs across one rising edge, then settles
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Watchdog reference: one flat cycle count since the last restart
  task automatic modelEdge();
    logic wset;
    wset = 1'b0;
    if (!(en && cfg != 8'd0)) begin
      mc = 0;
    end else if (rfsh) begin
`ifdef LV_WDG_WINDOW_EN
      if ((mc / P) < int'(cfg >> 1)) wset = 1'b1;
`endif
      mc = 0;
    end else if (mc == P * int'(cfg)) begin
      wset = 1'b1;
      mc = 0;
    end else begin
      mc++;
    end
    if (wset) merr = 1'b1;
    else if (wclr) merr = 1'b0;
  endtask

  task automatic prepScan();
    en = 1'b0; ack = 1'b0; crc = 1'b0; oclr = 1'b1; wclr = 1'b1;
    applyStimulus();
    oclr = 1'b0; wclr = 1'b0;
  endtask

  // Enables at t=0 and acts as the OWT responder, recording request shape
  task automatic runScan(input int ncyc, input int ack_dly, input int good_from, input int stray_dly);
    int last_rise;
    int nreq;
    logic prev;
    rises.delete();
    lens.delete();
    prev = 1'b0;
    last_rise = -1000;
    nreq = 0;
    en = 1'b1;
    t = 0;
    for (int k = 0; k < ncyc; k++) begin
      applyStimulus();
      ack = 1'b0;
      crc = 1'b0;
      if (req && !prev) begin
        rises.push_back(t);
        last_rise = t;
        nreq++;
      end
      if (!req && prev) lens.push_back(t - last_rise);
      prev = req;
      retry_hist[t] = int'(retry);
      owt_hist[t] = int'(owt_err);
      if (ack_dly >= 0 && req && t == last_rise + ack_dly) begin
        ack = 1'b1;
        crc = (nreq > good_from);
      end else if (stray_dly >= 0 && !req && t == last_rise + stray_dly) begin
        ack = 1'b1;
        crc = 1'b0;
      end
    end
    ack = 1'b0;
    crc = 1'b0;
  endtask

  initial begin
    $display("[TB] reset");
    #23;
    checkOutput("rst_req", req, 1'b0);
    checkOutput("rst_wdg", wdg_err, 1'b0);
    checkOutput("rst_owt", owt_err, 1'b0);
    checkOutput("rst_retry", retry, 2'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus();

    $display("[TB] watchdog timeout");
    cfg = 8'd4;
    en = 1'b1;
    t = 0;
    for (int k = 0; k < 33; k++) begin
      applyStimulus();
      if (t == 32) checkOutput("wdg_before_tmo", wdg_err, 1'b0);
      if (t == 33) checkOutput("wdg_tmo_33", wdg_err, 1'b1);
    end
    wclr = 1'b1;
    applyStimulus();
    wclr = 1'b0;
    checkOutput("wdg_clr", wdg_err, 1'b0);

    $display("[TB] watchdog refreshed");
    en = 1'b0;
    applyStimulus();
    en = 1'b1;
    for (int i = 1; i <= 500; i++) begin
      rfsh = (i % 20 == 0);
      applyStimulus();
      checkOutput("wdg_rfsh_held", wdg_err, 1'b0);
    end
    for (int j = 1; j <= 33; j++) begin
      rfsh = (j == 33);
      applyStimulus();
    end
    rfsh = 1'b0;
    checkOutput("wdg_rfsh_terminal", wdg_err, 1'b0);
    for (int j = 1; j <= 33; j++) begin
      applyStimulus();
      if (j == 32) checkOutput("wdg_pre_tmo2", wdg_err, 1'b0);
      if (j == 33) checkOutput("wdg_tmo_after_rfsh", wdg_err, 1'b1);
    end
    for (int j = 1; j <= 33; j++) begin
      wclr = (j == 33);
      applyStimulus();
    end
    wclr = 1'b0;
    checkOutput("wdg_set_beats_clr", wdg_err, 1'b1);
    wclr = 1'b1;
    applyStimulus();
    wclr = 1'b0;
    checkOutput("wdg_clr2", wdg_err, 1'b0);

    cfg = 8'd0;
    repeat (100) applyStimulus();
    checkOutput("wdg_cfg0", wdg_err, 1'b0);

`ifdef LV_WDG_WINDOW_EN
    $display("[TB] window watchdog");
    en = 1'b0;
    cfg = 8'd8;
    applyStimulus();
    en = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      rfsh = (n == 20);
      applyStimulus();
    end
    rfsh = 1'b0;
    checkOutput("win_early", wdg_err, 1'b1);
    for (int n = 1; n <= 45; n++) begin
      wclr = (n == 1);
      rfsh = (n == 45);
      applyStimulus();
    end
    rfsh = 1'b0;
    wclr = 1'b0;
    checkOutput("win_late", wdg_err, 1'b0);
    cfg = 8'd0;
`endif

    $display("[TB] scan good acks");
    prepScan();
    runScan(81, 5, 0, 8);
    checkOutput("good_nreq", rises.size(), 5);
    for (int i = 0; i < rises.size(); i++) checkOutput("good_rise", rises[i], 11 + 17 * i);
    for (int i = 0; i < lens.size(); i++) checkOutput("good_len", lens[i], 6);
    checkOutput("good_retry", retry_hist[81], 0);
    checkOutput("good_owt", owt_hist[81], 0);

    $display("[TB] scan mixed crc");
    prepScan();
    runScan(35, 2, 2, -1);
    checkOutput("mix_retry1", retry_hist[14], 1);
    checkOutput("mix_retry2", retry_hist[18], 2);
    checkOutput("mix_retry0", retry_hist[22], 0);
    checkOutput("mix_nreq", rises.size(), 4);
    if (rises.size() == 4) begin
      checkOutput("mix_rise1", rises[1], 15);
      checkOutput("mix_rise2", rises[2], 19);
      checkOutput("mix_rise3", rises[3], 33);
    end
    checkOutput("mix_owt", owt_hist[35], 0);

    $display("[TB] scan timeouts");
    prepScan();
    runScan(80, -1, 0, -1);
    checkOutput("tmo_nreq", rises.size(), 3);
    if (rises.size() == 3) begin
      checkOutput("tmo_rise0", rises[0], 11);
      checkOutput("tmo_rise1", rises[1], 32);
      checkOutput("tmo_rise2", rises[2], 53);
    end
    for (int i = 0; i < lens.size(); i++) checkOutput("tmo_len", lens[i], 20);
    checkOutput("tmo_retry1", retry_hist[31], 1);
    checkOutput("tmo_retry2", retry_hist[52], 2);
    checkOutput("tmo_owt_pre", owt_hist[72], 0);
    checkOutput("tmo_owt_set", owt_hist[73], 1);
    checkOutput("tmo_retry_clr", retry_hist[73], 0);

    $display("[TB] enable drop");
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      applyStimulus();
      if (req) found = 1'b1;
    end
    checkOutput("req_before_drop", req, 1'b1);
    en = 1'b0;
    applyStimulus();
    checkOutput("req_drop", req, 1'b0);
    checkOutput("owt_hold_drop", owt_err, 1'b1);
    repeat (3) applyStimulus();
    checkOutput("owt_hold_idle", owt_err, 1'b1);
    runScan(14, -1, 0, -1);
    checkOutput("reen_nreq", rises.size(), 1);
    if (rises.size() >= 1) checkOutput("reen_first_req", rises[0], 11);
    checkOutput("reen_owt", owt_hist[14], 1);

    $display("[TB] random watchdog");
    en = 1'b0; wclr = 1'b1; rfsh = 1'b0;
    applyStimulus();
    wclr = 1'b0;
    mc = 0;
    merr = 1'b0;
    for (int r = 0; r < 6; r++) begin
      cfg = 8'($urandom_range(1, 5));
      for (int k = 0; k < 300; k++) begin
        en   = (k != 0) && ($urandom_range(0, 99) != 0);
        rfsh = ($urandom_range(0, 34) == 0);
        wclr = ($urandom_range(0, 24) == 0);
        modelEdge();
        applyStimulus();
        checkOutput("wdg_random", wdg_err, merr);
      end
    end
    rfsh = 1'b0;
    wclr = 1'b0;

    $display("[TB] async reset");
    checkOutput("owt_before_rst", owt_err, 1'b1);
    rst_n = 1'b0;
    #2;
    checkOutput("arst_owt", owt_err, 1'b0);
    checkOutput("arst_wdg", wdg_err, 1'b0);
    checkOutput("arst_req", req, 1'b0);
    checkOutput("arst_retry", retry, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
